// File: rtl/vga_timing.sv
// VGA raster timing generator: h/v counters advanced by pix_en, registered syncs/coords/pulses.
// Optional VGA_FRAME_CNT_EN adds a 16-bit wrapping frame counter output.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic SP = 1'(SYNC_POL);

    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;
    logic          h_wrap, act_nxt, hs_nxt, vs_nxt;

    // Outputs are decoded from the post-edge counter values so they line up with h_cnt/v_cnt.
    always_comb begin
        h_wrap  = (h_cnt == HW'(H_TOTAL - 1));
        h_nxt   = h_wrap ? '0 : h_cnt + 1'b1;
        v_nxt   = v_cnt;
        if (h_wrap)
            v_nxt = (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        act_nxt = (h_nxt < HW'(H_ACTIVE)) && (v_nxt < VW'(V_ACTIVE));
        hs_nxt  = (h_nxt >= HW'(H_ACTIVE + H_FP)) && (h_nxt < HW'(H_ACTIVE + H_FP + H_SYNC));
        vs_nxt  = (v_nxt >= VW'(V_ACTIVE + V_FP)) && (v_nxt < VW'(V_ACTIVE + V_FP + V_SYNC));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= HW'(H_TOTAL - 1);
            v_cnt       <= VW'(V_TOTAL - 1);
            active      <= 1'b0;
            x           <= '0;
            y           <= '0;
            hsync       <= ~SP;
            vsync       <= ~SP;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                h_cnt       <= h_nxt;
                v_cnt       <= v_nxt;
                active      <= act_nxt;
                x           <= act_nxt ? 10'(h_nxt) : '0;
                y           <= act_nxt ? 10'(v_nxt) : '0;
                hsync       <= hs_nxt ? SP : ~SP;
                vsync       <= vs_nxt ? SP : ~SP;
                line_start  <= (h_nxt == '0);
                frame_start <= (h_nxt == '0) && (v_nxt == '0);
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_cnt <= '0;
        else if (pix_en && h_nxt == '0 && v_nxt == '0)
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a small-geometry instance and a default 640x480 instance driven in lockstep,
// checked against a linear-pixel-index reference model, a vector table and directed sequences.
module tb_vga_timing;
    localparam int AHA = 16, AHF = 4, AHS = 6, AHB = 5;
    localparam int AVA = 12, AVF = 2, AVS = 2, AVB = 3;
    localparam int AHT = AHA + AHF + AHS + AHB;
    localparam int AVT = AVA + AVF + AVS + AVB;
    localparam int BHT = 800, BVT = 525;

    logic clk = 1'b0;
    logic rst, pix_en;
    logic a_hs, a_vs, a_act, a_ls, a_fs, b_hs, b_vs, b_act, b_ls, b_fs;
    logic [9:0] a_x, a_y, b_x, b_y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] a_fc, b_fc;
`endif

    vga_timing #(.H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
                 .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB), .SYNC_POL(0)) dut_a (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(a_hs), .vsync(a_vs), .active(a_act),
        .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(a_fc)
`endif
    );

    vga_timing dut_b (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(b_hs), .vsync(b_vs), .active(b_act),
        .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(b_fc)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;
    int pa, pb, fca, fcb;
    bit lsa, fsa, lsb, fsb;

    logic [24:0] got_a, got_b;
    assign got_a = {a_hs, a_vs, a_act, a_ls, a_fs, a_x, a_y};
    assign got_b = {b_hs, b_vs, b_act, b_ls, b_fs, b_x, b_y};

    function automatic logic [24:0] mk(bit hs, bit vs, bit act, bit ls, bit fs, int xx, int yy);
        return {hs, vs, act, ls, fs, 10'(xx), 10'(yy)};
    endfunction

    // Expected outputs from a frame-linear pixel index p (h = p mod H_TOTAL, v = p div H_TOTAL).
    function automatic logic [24:0] expw(int p, int ht, int ha, int hf, int hs, int va, int vf, int vs,
                                         bit ls, bit fs);
        int  h = p % ht;
        int  v = p / ht;
        bit  act = (h < ha) && (v < va);
        bit  hsy = !((h >= ha + hf) && (h < ha + hf + hs));
        bit  vsy = !((v >= va + vf) && (v < va + vf + vs));
        return mk(hsy, vsy, act, ls, fs, act ? h : 0, act ? v : 0);
    endfunction

    task automatic check(input string nm, input logic [24:0] got, input logic [24:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic check_models(input string nm);
        check({nm, "_a"}, got_a, expw(pa, AHT, AHA, AHF, AHS, AVA, AVF, AVS, lsa, fsa));
        check({nm, "_b"}, got_b, expw(pb, BHT, 640, 16, 96, 480, 10, 2, lsb, fsb));
`ifdef VGA_FRAME_CNT_EN
        check_int({nm, "_fca"}, int'(a_fc), fca);
        check_int({nm, "_fcb"}, int'(b_fc), fcb);
`endif
    endtask

    task automatic model_reset();
        pa = AHT * AVT - 1; pb = BHT * BVT - 1;
        lsa = 0; fsa = 0; lsb = 0; fsb = 0; fca = 0; fcb = 0;
    endtask

    task automatic model_edge(input bit en);
        if (en) begin
            pa  = (pa + 1) % (AHT * AVT);
            pb  = (pb + 1) % (BHT * BVT);
            lsa = (pa % AHT == 0); fsa = (pa == 0);
            lsb = (pb % BHT == 0); fsb = (pb == 0);
            if (fsa) fca = (fca + 1) % 65536;
            if (fsb) fcb = (fcb + 1) % 65536;
        end else begin
            lsa = 0; fsa = 0; lsb = 0; fsb = 0;
        end
    endtask

    task automatic step(input bit en, input bit r, input string nm);
        pix_en = en;
        rst    = r;
        @(posedge clk);
        if (r) model_reset();
        else   model_edge(en);
        @(negedge clk);
        check_models(nm);
    endtask

    typedef struct {
        bit          en;
        bit          r;
        logic [24:0] exp;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int e, last, hl, ac, fe, flast, vl, ymax, guard;
        bit ldone, fdone;
        logic [24:0] held;

        rst = 1'b1; pix_en = 1'b0;
        model_reset();

        // Small instance: reset, first edge to (0,0), holds and single advances.
        tbl[0] = '{en: 0, r: 1, exp: mk(1, 1, 0, 0, 0, 0, 0)};
        tbl[1] = '{en: 1, r: 0, exp: mk(1, 1, 1, 1, 1, 0, 0)};
        tbl[2] = '{en: 0, r: 0, exp: mk(1, 1, 1, 0, 0, 0, 0)};
        tbl[3] = '{en: 1, r: 0, exp: mk(1, 1, 1, 0, 0, 1, 0)};
        tbl[4] = '{en: 1, r: 0, exp: mk(1, 1, 1, 0, 0, 2, 0)};
        tbl[5] = '{en: 0, r: 0, exp: mk(1, 1, 1, 0, 0, 2, 0)};
        tbl[6] = '{en: 1, r: 0, exp: mk(1, 1, 1, 0, 0, 3, 0)};
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].en, tbl[i].r, "tbl_model");
            check($sformatf("tbl%0d", i), got_a, tbl[i].exp);
        end

        // pix_en every other clk: line period/hsync/active on default geometry, frame period on small one.
        e = 0; last = -1; hl = 0; ac = 0; ldone = 0;
        fe = 0; flast = -1; vl = 0; ymax = 0; fdone = 0;
        for (int i = 0; i < 3400; i++) begin
            step(i[0], 0, "run");
            if (i[0]) begin
                e++;
                if (b_ls) begin
                    if (last >= 0 && !ldone) begin
                        check_int("line_period", e - last, 800);
                        check_int("hsync_low_px", hl, 96);
                        check_int("active_px", ac, 640);
                        ldone = 1;
                    end
                    last = e; hl = 0; ac = 0;
                end
                if (!b_hs) hl++;
                if (b_act) ac++;
                if (a_fs) begin
                    if (flast >= 0 && !fdone) begin
                        check_int("frame_period", e - flast, AHT * AVT);
                        check_int("vsync_low_px", vl, AVS * AHT);
                        check_int("y_max", ymax, AVA - 1);
                        fdone = 1;
                    end
                    flast = e; vl = 0; ymax = 0;
                end
                if (!a_vs) vl++;
                if (a_act && int'(a_y) > ymax) ymax = int'(a_y);
            end
        end
        if (!ldone) check_int("line_measure_timeout", 0, 1);
        if (!fdone) check_int("frame_measure_timeout", 0, 1);

        // Freeze at h=700 of the default geometry for 50 clks, then resume.
        guard = 0;
        while (pb % BHT != 700 && guard < 1000) begin step(1, 0, "seek700"); guard++; end
        check_int("seek700_reached", pb % BHT, 700);
        held = got_b;
        for (int i = 0; i < 50; i++) begin
            step(0, 0, "hold");
            check("hold_frozen", got_b, {held[24:22], 2'b00, held[19:0]});
        end
        step(1, 0, "resume");
        check("resume_701", {b_hs, b_act, b_ls}, 3'b000);

        // Asynchronous reset mid-frame on the small geometry at (8,6).
        guard = 0;
        while (pa != 6 * AHT + 8 && guard < 1000) begin step(1, 0, "seek_mid"); guard++; end
        check("mid_pos", got_a, mk(1, 1, 1, 0, 0, 8, 6));
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_a", got_a, mk(1, 1, 0, 0, 0, 0, 0));
        check("async_rst_b", got_b, mk(1, 1, 0, 0, 0, 0, 0));
        step(1, 0, "post_rst");
        check("post_rst_00", got_a, mk(1, 1, 1, 1, 1, 0, 0));

        // Random pix_en patterns with occasional resets.
        for (int i = 0; i < 20000; i++)
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 999) == 0), "rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 The block SHALL have parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BP, 33, vertical back porch in lines.
REQ-009 The block SHALL have parameter SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low).
REQ-010 The block SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-011 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-012 The block SHALL have port pix_en, input, 1, pixel-advance enable from the clk/2 divider, synchronous to clk.
REQ-013 The block SHALL have port hsync, output, 1, horizontal sync.
REQ-014 The block SHALL have port vsync, output, 1, vertical sync.
REQ-015 The block SHALL have port active, output, 1, high while the current pixel is visible.
REQ-016 The block SHALL have port x, output, 10, horizontal pixel coordinate.
REQ-017 The block SHALL have port y, output, 10, vertical line coordinate.
REQ-018 The block SHALL have port line_start, output, 1, one-clk pulse on entry to h=0.
REQ-019 The block SHALL have port frame_start, output, 1, one-clk pulse on entry to (h,v)=(0,0).

Function
REQ-020 Internal counters h_cnt (0..H_TOTAL-1, H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP) and v_cnt (0..V_TOTAL-1, defined likewise) SHALL change only on clk edges where pix_en=1.
REQ-021 On a pix_en edge, h_cnt SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and v_cnt SHALL increment, with v_cnt wrapping from V_TOTAL-1 to 0.
REQ-022 All outputs SHALL be registered, reflect the counter values after the same edge, and have no combinational path from any input.
REQ-023 active SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-024 x SHALL equal h_cnt and y SHALL equal v_cnt while active=1; both SHALL be 0 while active=0.
REQ-025 hsync SHALL equal SYNC_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
REQ-026 vsync SHALL equal SYNC_POL iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else ~SYNC_POL, independent of h_cnt.
REQ-027 line_start SHALL be high for exactly one clk cycle following each pix_en edge that loads h_cnt=0; frame_start likewise for (0,0).
REQ-028 With pix_en held 0, all outputs SHALL hold, except line_start/frame_start which SHALL return to 0 after one cycle.
REQ-029 pix_en asserted on consecutive clk cycles SHALL advance one pixel per cycle (no pulse-width assumption).

Reset
REQ-030 rst SHALL force h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, active=0, x=0, y=0, hsync=vsync=~SYNC_POL, line_start=frame_start=0.
REQ-031 The first pix_en edge after reset release SHALL enter (0,0) and pulse both line_start and frame_start.
REQ-032 rst asserted mid-frame SHALL take effect immediately, with no partial line or frame completed.

Configuration
REQ-033 With macro VGA_FRAME_CNT_EN defined, the block SHALL add port frame_cnt, output, 16, reset to 0, incremented with each frame_start pulse, wrapping 65535->0.
REQ-034 Without VGA_FRAME_CNT_EN, port frame_cnt and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-035 Reset, then pix_en=1 every other clk -> first pix_en edge gives x=0, y=0, active=1, line_start=frame_start=1 for one clk.
REQ-036 Run one line -> active high for pixels 0..639, hsync low for h 656..751 (96 pixels), next line_start 800 pix_en edges after the previous one.
REQ-037 Run one frame -> vsync low for lines 490..491 only; frame_start period of 420000 pix_en edges; y max 479.
REQ-038 Hold pix_en=0 for 50 clks at h=700 -> outputs frozen, no pulses; resume -> h=701.
REQ-039 Assert rst at (h=320, v=240) -> outputs at reset values within the same cycle; next pix_en edge -> (0,0) with frame_start.
REQ-040 With VGA_FRAME_CNT_EN: preload by running 65536 frames (or force) -> frame_cnt wraps 65535->0 on frame_start.
